// File: rtl/hamming_pkg.sv
// Shared types and sizing helpers for the Hamming SECDED engine.
package hamming_pkg;

    // Smallest r such that 2^r >= data_w + r + 1.
    function automatic int unsigned calc_pw(input int unsigned data_w);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < (data_w + r + 32'd1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'b00,
        ST_CORR   = 2'b01,
        ST_P0     = 2'b10,
        ST_UNCORR = 2'b11
    } status_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/parity core: s = XOR of indices of set bits 1..CODE_W-1,
// q = XOR of all bits.
module hamming_syndrome #(
    parameter int unsigned CODE_W = 16,
    parameter int unsigned P_W    = 4
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [P_W-1:0]    s_o,
    output logic              q_o
);

    always_comb begin
        s_o = '0;
        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (code_i[i]) begin
                s_o = s_o ^ P_W'(i);
            end
        end
        q_o = ^code_i;
    end

endmodule

// File: rtl/hamming_secded_engine.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready flow
// control and saturating error counters.
module hamming_secded_engine
    import hamming_pkg::*;
#(
    parameter  int unsigned DATA_W = 11,
    parameter  int unsigned CNT_W  = 8,
    localparam int unsigned P_W    = calc_pw(DATA_W),
    localparam int unsigned CODE_W = DATA_W + P_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_data,
    output logic [1:0]        out_status,
    output logic [P_W-1:0]    out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  err_corr_cnt,
    output logic [CNT_W-1:0]  err_dbl_cnt
);

    // Scatter payload into non-power-of-two positions, parity slots left zero.
    function automatic logic [CODE_W-1:0] place(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] rem;
        place = '0;
        rem   = d;
        for (int pos = 1; pos < int'(CODE_W); pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                place[pos] = rem[0];
                rem        = rem >> 1;
            end
        end
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] w);
        extract = '0;
        for (int pos = int'(CODE_W) - 1; pos > 0; pos--) begin
            if ((pos & (pos - 1)) != 0) begin
                extract = {extract[DATA_W-2:0], w[pos]};
            end
        end
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic              s1_mode_q, s1_mode_d;
    logic [CODE_W-1:0] s1_word_q, s1_word_d;
    logic [P_W-1:0]    s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_mode_q, s2_mode_d;
    logic [CODE_W-1:0] s2_data_q, s2_data_d;
    status_e           s2_status_q, s2_status_d;
    logic [P_W-1:0]    s2_syn_q, s2_syn_d;

    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  dbl_cnt_q, dbl_cnt_d;

    logic [CODE_W-1:0] syn_in;
    logic [P_W-1:0]    syn_s;
    logic              syn_q;
    logic              s2_accept;
    logic              xfer_dec;

    logic [CODE_W-1:0] res_word;
    logic [CODE_W-1:0] res_data;
    status_e           res_status;
    logic [P_W-1:0]    res_syn;

    // Encode reuses the syndrome core: s over the placed payload is the parity vector.
    assign syn_in = (in_mode == MODE_DEC) ? in_data : place(in_data[DATA_W-1:0]);

    hamming_syndrome #(
        .CODE_W(CODE_W),
        .P_W   (P_W)
    ) u_syndrome (
        .code_i(syn_in),
        .s_o   (syn_s),
        .q_o   (syn_q)
    );

    assign s2_accept = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || s2_accept;
    assign xfer_dec  = s2_valid_q && out_ready && (s2_mode_q == MODE_DEC);

    // Stage-2 result: finish the codeword or classify and correct the received word.
    always_comb begin
        res_word   = s1_word_q;
        res_data   = '0;
        res_status = ST_CLEAN;
        res_syn    = '0;
        if (s1_mode_q == MODE_ENC) begin
            for (int unsigned k = 0; k < P_W; k++) begin
                res_word[32'd1 << k] = s1_syn_q[k];
            end
            res_word[0] = ^res_word[CODE_W-1:1];
            res_data    = res_word;
        end else begin
            res_syn = s1_syn_q;
            if (s1_syn_q == '0) begin
                res_status = s1_par_q ? ST_P0 : ST_CLEAN;
            end else if (!s1_par_q || (32'(s1_syn_q) > (CODE_W - 32'd1))) begin
                res_status = ST_UNCORR;
            end else begin
                res_status = ST_CORR;
                res_word   = s1_word_q ^ (CODE_W'(1) << s1_syn_q);
            end
            res_data = CODE_W'(extract(res_word));
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_mode_d   = s1_mode_q;
        s1_word_d   = s1_word_q;
        s1_syn_d    = s1_syn_q;
        s1_par_d    = s1_par_q;
        s2_valid_d  = s2_valid_q;
        s2_mode_d   = s2_mode_q;
        s2_data_d   = s2_data_q;
        s2_status_d = s2_status_q;
        s2_syn_d    = s2_syn_q;
        corr_cnt_d  = corr_cnt_q;
        dbl_cnt_d   = dbl_cnt_q;

        if (in_valid && in_ready) begin
            s1_valid_d = 1'b1;
            s1_mode_d  = in_mode;
            s1_word_d  = syn_in;
            s1_syn_d   = syn_s;
            s1_par_d   = syn_q;
        end else if (s2_accept) begin
            s1_valid_d = 1'b0;
        end

        if (s2_accept) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_mode_d   = s1_mode_q;
                s2_data_d   = res_data;
                s2_status_d = res_status;
                s2_syn_d    = res_syn;
            end
        end

        // Clear has priority over a same-cycle event.
        if (cnt_clr) begin
            corr_cnt_d = '0;
            dbl_cnt_d  = '0;
        end else if (xfer_dec) begin
            if (((s2_status_q == ST_CORR) || (s2_status_q == ST_P0)) && (corr_cnt_q != '1)) begin
                corr_cnt_d = corr_cnt_q + CNT_W'(1);
            end
            if ((s2_status_q == ST_UNCORR) && (dbl_cnt_q != '1)) begin
                dbl_cnt_d = dbl_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_ENC;
            s1_word_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= MODE_ENC;
            s2_data_q   <= '0;
            s2_status_q <= ST_CLEAN;
            s2_syn_q    <= '0;
            corr_cnt_q  <= '0;
            dbl_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_word_q   <= s1_word_d;
            s1_syn_q    <= s1_syn_d;
            s1_par_q    <= s1_par_d;
            s2_valid_q  <= s2_valid_d;
            s2_mode_q   <= s2_mode_d;
            s2_data_q   <= s2_data_d;
            s2_status_q <= s2_status_d;
            s2_syn_q    <= s2_syn_d;
            corr_cnt_q  <= corr_cnt_d;
            dbl_cnt_q   <= dbl_cnt_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_mode     = s2_mode_q;
    assign out_data     = s2_data_q;
    assign out_status   = s2_status_q;
    assign out_syndrome = s2_syn_q;
    assign err_corr_cnt = corr_cnt_q;
    assign err_dbl_cnt  = dbl_cnt_q;

endmodule
